// File: rtl/gcd_pkg.sv
// gcd_pkg: shared width, arbiter state encoding and the round-robin search used by gcd_arbiter.
package gcd_pkg;
    localparam int GCD_W = 16;
    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} gcd_arb_state_t;
    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_t;
    // First set bit of req[n-1:0] at or above ptr, wrapping modulo n (ptr < n <= 8).
    function automatic rr_t rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
        rr_t r;
        logic [3:0] s;
        logic [2:0] j;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            s = {1'b0, ptr} + 4'(i);
            j = 3'((s >= 4'(n)) ? s - 4'(n) : s);
            if (i < n && !r.found && req[j]) begin
                r.found = 1'b1;
                r.idx   = j;
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/gcd2.sv
// gcd2: subtractive GCD engine; one-cycle valid pulse with out = gcd(a_in, b_in), gcd(x,0) = x.
module gcd2
    import gcd_pkg::*;
#(
    parameter int W = GCD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic         valid,
    output logic [W-1:0] out
);
    logic         run;
    logic [W-1:0] x, y;
    always_ff @(posedge clk) begin
        if (rst) begin
            run   <= 1'b0;
            x     <= '0;
            y     <= '0;
            valid <= 1'b0;
            out   <= '0;
        end else begin
            valid <= 1'b0;
            if (start) begin
                x   <= a_in;
                y   <= b_in;
                run <= 1'b1;
            end else if (run) begin
                if (x == '0 || y == '0) begin
                    out   <= x | y;
                    valid <= 1'b1;
                    run   <= 1'b0;
                end else if (x >= y) begin
                    x <= x - y;
                end else begin
                    y <= y - x;
                end
            end
        end
    end
endmodule

// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin sharing of a single gcd2 engine among N requesters.
module gcd_arbiter
    import gcd_pkg::*;
#(
    parameter int N = 4,
    parameter int W = GCD_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] a,
    input  logic [N*W-1:0] b,
    output logic [N-1:0]   ack,
    output logic [N-1:0]   done,
    output logic [W-1:0]   result,
    output logic           busy
);
    gcd_arb_state_t state;
    rr_t            pick;
    logic [2:0]     ptr, gnt;
    logic [N-1:0]   pick_hot, gnt_hot;
    logic [W-1:0]   a_sel, b_sel, a_q, b_q, g_out;
    logic           start, valid;
    always_comb begin
        pick     = rr_pick(8'(req), ptr, N);
        a_sel    = '0;
        b_sel    = '0;
        pick_hot = '0;
        gnt_hot  = '0;
        for (int i = 0; i < N; i++) begin
            pick_hot[i] = (3'(i) == pick.idx);
            gnt_hot[i]  = (3'(i) == gnt);
            a_sel       = pick_hot[i] ? a[i*W +: W] : a_sel;
            b_sel       = pick_hot[i] ? b[i*W +: W] : b_sel;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ptr    <= '0;
            gnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            ack    <= '0;
            done   <= '0;
            result <= '0;
            busy   <= 1'b0;
            start  <= 1'b0;
        end else begin
            ack   <= '0;
            done  <= '0;
            start <= 1'b0;
            case (state)
                IDLE: if (pick.found) begin
                    a_q   <= a_sel;
                    b_q   <= b_sel;
                    gnt   <= pick.idx;
                    ptr   <= (pick.idx == 3'(N - 1)) ? 3'd0 : pick.idx + 3'd1;
                    ack   <= pick_hot;
                    start <= 1'b1;
                    busy  <= 1'b1;
                    state <= ISSUE;
                end
                ISSUE: state <= BUSY;
                BUSY: if (valid) begin
                    result <= g_out;
                    done   <= gnt_hot;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    gcd2 #(.W(W)) u_gcd (
        .clk  (clk),
        .rst  (reset),
        .start(start),
        .a_in (a_q),
        .b_in (b_q),
        .valid(valid),
        .out  (g_out)
    );
endmodule

// File: tb/tb_gcd_arbiter.sv
// tb_gcd_arbiter: directed and randomized checks of gcd_arbiter against an arithmetic round-robin model.
module tb_gcd_arbiter;
    localparam int N = 4;
    localparam int W = 16;
    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [W-1:0]   av [N];
    logic [W-1:0]   bv [N];
    logic [N*W-1:0] a, b;
    logic [N-1:0]   ack, done;
    logic [W-1:0]   result;
    logic           busy;
    int total = 0;
    int bad = 0;
    int q_ack[$];
    int q_done[$];
    int q_res[$];
    assign a = {av[3], av[2], av[1], av[0]};
    assign b = {bv[3], bv[2], bv[1], bv[0]};
    always #5 clk = ~clk;
    gcd_arbiter #(.N(N), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .a     (a),
        .b     (b),
        .ack   (ack),
        .done  (done),
        .result(result),
        .busy  (busy)
    );
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    function automatic int gcd_ref(input int x, input int y);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction
    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction
    function automatic int qcount(input int q[$], input int v);
        int c = 0;
        foreach (q[i]) if (q[i] == v) c++;
        return c;
    endfunction
    function automatic logic [W-1:0] rnd();
        return ($urandom_range(0, 15) == 0) ? '0 : W'($urandom_range(1, 255));
    endfunction
    // Model: inputs seen at one negedge are what the DUT sampled at the following posedge.
    logic           p_rst = 1'b1;
    logic [N-1:0]   p_req = '0;
    logic [N*W-1:0] p_a = '0;
    logic [N*W-1:0] p_b = '0;
    bit             m_out = 1'b0;
    int             m_ptr = 0;
    int             m_gnt = 0;
    int             m_age = 0;
    int             m_exp = 0;
    int             m_res = 0;
    always @(negedge clk) begin
        int g;
        logic [N-1:0] e_ack, e_done;
        e_ack  = '0;
        e_done = '0;
        if (p_rst) begin
            m_out = 1'b0;
            m_ptr = 0;
            m_res = 0;
        end else if (!m_out) begin
            if (p_req != '0) begin
                g = m_ptr;
                while (!p_req[g]) g = (g + 1) % N;
                e_ack[g] = 1'b1;
                m_gnt = g;
                m_ptr = (g + 1) % N;
                m_out = 1'b1;
                m_age = 0;
                m_exp = gcd_ref(int'(p_a[g*W +: W]), int'(p_b[g*W +: W]));
            end
        end else begin
            m_age++;
            if (done != '0) begin
                e_done[m_gnt] = 1'b1;
                chk("done_latency", int'(m_age >= 3), 1);
                m_res = m_exp;
                m_out = 1'b0;
            end else if (m_age > 2000) begin
                chk("done_timeout", 0, 1);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
        chk("ack", int'(ack), int'(e_ack));
        chk("done", int'(done), int'(e_done));
        chk("result", int'(result), m_res);
        chk("busy", int'(busy), int'(m_out));
        for (int i = 0; i < N; i++) begin
            if (ack[i]) q_ack.push_back(i);
            if (done[i]) begin
                q_done.push_back(i);
                q_res.push_back(int'(result));
            end
        end
        p_rst = reset;
        p_req = req;
        p_a   = a;
        p_b   = b;
    end
    task automatic tick();
        @(posedge clk);
        #2;
    endtask
    task automatic clear_q();
        q_ack.delete();
        q_done.delete();
        q_res.delete();
    endtask
    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        tick();
        tick();
        reset = 1'b0;
        clear_q();
    endtask
    task automatic wait_done();
        int n = 0;
        while (done == '0 && n < 3000) begin
            tick();
            n++;
        end
        if (done == '0) chk("wait_done", 0, 1);
    endtask
    task automatic wait_idle();
        int n = 0;
        while (busy && n < 3000) begin
            tick();
            n++;
        end
        if (busy) chk("wait_idle", 0, 1);
    endtask
    int e2_res[4] = '{6, 6, 1, 25};
    int e3_ack[4] = '{0, 2, 0, 2};
    initial begin
        for (int i = 0; i < N; i++) begin
            av[i] = '0;
            bv[i] = '0;
        end
        chk("ref_48_18", gcd_ref(48, 18), 6);
        chk("ref_0_7", gcd_ref(0, 7), 7);
        chk("ref_9_0", gcd_ref(9, 0), 9);
        chk("ref_0_0", gcd_ref(0, 0), 0);
        // single requester
        do_reset();
        av[0] = 48; bv[0] = 18; req = 4'b0001;
        tick();
        chk("p1_ack", int'(ack), 1);
        chk("p1_busy_up", int'(busy), 1);
        req = '0;
        wait_done();
        chk("p1_done", int'(done), 1);
        chk("p1_result", int'(result), 6);
        tick();
        chk("p1_busy_low", int'(busy), 0);
        chk("p1_result_hold", int'(result), 6);
        // all four at once
        do_reset();
        av[0] = 48;  bv[0] = 18;
        av[1] = 270; bv[1] = 192;
        av[2] = 17;  bv[2] = 5;
        av[3] = 100; bv[3] = 75;
        req = 4'b1111;
        for (int n = 0; n < 3000 && q_done.size() < 4; n++) begin
            tick();
            req &= ~ack;
        end
        for (int i = 0; i < 4; i++) begin
            chk("p2_ack_order", qat(q_ack, i), i);
            chk("p2_done_order", qat(q_done, i), i);
            chk("p2_result", qat(q_res, i), e2_res[i]);
        end
        // fairness between 0 and 2
        do_reset();
        av[0] = 9;  bv[0] = 6;
        av[2] = 35; bv[2] = 14;
        req = 4'b0101;
        for (int n = 0; n < 3000 && q_done.size() < 4; n++) tick();
        req = '0;
        for (int i = 0; i < 4; i++) chk("p3_ack_order", qat(q_ack, i), e3_ack[i]);
        chk("p3_res0", qat(q_res, 0), 3);
        chk("p3_res1", qat(q_res, 1), 7);
        wait_idle();
        // late request ignored while busy
        do_reset();
        av[1] = 21; bv[1] = 14; req = 4'b0010;
        tick();
        chk("p4_ack1", int'(ack), 2);
        req = '0;
        tick();
        tick();
        av[3] = 40; bv[3] = 24; req = 4'b1000;
        wait_done();
        chk("p4_done1", int'(done), 2);
        chk("p4_no_ack_with_done", int'(ack), 0);
        chk("p4_result1", int'(result), 7);
        tick();
        chk("p4_ack3", int'(ack), 8);
        req = '0;
        wait_done();
        chk("p4_done3", int'(done), 8);
        chk("p4_result3", int'(result), 8);
        // withdrawn request
        do_reset();
        av[0] = 200; bv[0] = 3; req = 4'b0001;
        tick();
        req = '0;
        tick();
        tick();
        av[1] = 5; bv[1] = 10; req = 4'b0010;
        tick();
        req = '0;
        wait_done();
        repeat (5) tick();
        chk("p5_no_ack1", qcount(q_ack, 1), 0);
        chk("p5_no_done1", qcount(q_done, 1), 0);
        chk("p5_acks", q_ack.size(), 1);
        chk("p5_result", int'(result), 1);
        // reset mid-operation
        clear_q();
        av[2] = 250; bv[2] = 1; req = 4'b0100;
        tick();
        chk("p6_ack2", int'(ack), 4);
        req = '0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("p6_rst_ack", int'(ack), 0);
        chk("p6_rst_done", int'(done), 0);
        chk("p6_rst_busy", int'(busy), 0);
        chk("p6_rst_result", int'(result), 0);
        repeat (20) tick();
        chk("p6_no_done", q_done.size(), 0);
        av[0] = 12; bv[0] = 8; req = 4'b0001;
        tick();
        chk("p6_reack", int'(ack), 1);
        req = '0;
        wait_done();
        chk("p6_redone", int'(done), 1);
        chk("p6_reresult", int'(result), 4);
        // randomized traffic
        clear_q();
        for (int n = 0; n < 4000; n++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (req[i] && ack[i]) begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                    else begin
                        av[i] = rnd();
                        bv[i] = rnd();
                    end
                end else if (!req[i] && $urandom_range(0, 7) == 0) begin
                    av[i]  = rnd();
                    bv[i]  = rnd();
                    req[i] = 1'b1;
                end else if (req[i] && $urandom_range(0, 99) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
        req = '0;
        wait_idle();
        tick();
        chk("random_ops_seen", int'(q_done.size() > 20), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
